// File: rtl/proc_pkg.sv
// Shared opcode/state encodings and defaults for the program sequencer.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_LATCH_IMM = 3'd4,
        S_EXEC      = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam int TIMEOUT_DEFAULT = 15;

    function automatic opcode_t opcode_of(input logic [15:0] word);
        return opcode_t'(word[15:13]);
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Control, program-memory and processor handshake bundle of the sequencer.
interface proc_sequencer_if #(
    parameter int AW = 8
);
    logic          start;
    logic          stop;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic [15:0]   din;
    logic          run;
    logic          done;
    logic          busy;
    logic          halted;
    logic          error;
    logic [15:0]   instr_count;

    modport master (
        input  start, stop, start_addr, end_addr, mem_data, done,
        output mem_addr, din, run, busy, halted, error, instr_count
    );

    modport slave (
        output start, stop, start_addr, end_addr, mem_data, done,
        input  mem_addr, din, run, busy, halted, error, instr_count
    );
endinterface

// File: rtl/seq_watchdog.sv
// EXEC watchdog: down-counter loaded on clear, terminal count when it hits zero.
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;

    // Loaded with TIMEOUT-1 so tc is high during the TIMEOUT-th enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= CW'(TIMEOUT - 1);
        end else if (enable && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/proc_sequencer.sv
// Fetches instructions (and mvi immediates) from program memory and hands
// each to the processor, waiting for Done under a watchdog.
//   state      | meaning
//   IDLE       | waiting for start, or stopped by request
//   FETCH      | mem_addr = pc (instruction word)
//   LATCH      | capture instruction, pc++
//   FETCH_IMM  | mem_addr = pc (mvi immediate)
//   LATCH_IMM  | capture immediate, pc++
//   EXEC       | run = 1 until done or watchdog expiry
//   HALT       | pc reached end_addr
//   ERROR      | watchdog expired
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    proc_sequencer_if.master bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q;
    logic [15:0]   ir_q;
    logic [15:0]   imm_q;
    logic [15:0]   instr_count_q;
    logic          exec_first_q;
    logic          wd_tc;
    logic          is_mvi;
    logic [AW-1:0] mem_addr;
    logic [15:0]   din;
    logic          run;

    assign is_mvi = (opcode_of(ir_q) == OP_MVI);

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != S_EXEC),
        .enable (state_q == S_EXEC),
        .tc     (wd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mem_addr = '0;
        din      = 16'h0000;
        run      = 1'b0;
        case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (bus.start) state_d = (bus.start_addr == bus.end_addr) ? S_HALT : S_FETCH;
            end
            S_FETCH: begin
                mem_addr = pc_q;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                state_d = (opcode_of(bus.mem_data) == OP_MVI) ? S_FETCH_IMM : S_EXEC;
            end
            S_FETCH_IMM: begin
                mem_addr = pc_q;
                state_d  = S_LATCH_IMM;
            end
            S_LATCH_IMM: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                run = 1'b1;
                din = (exec_first_q || !is_mvi) ? ir_q : imm_q;
                // Done wins over a simultaneous watchdog expiry.
                if (bus.done) begin
                    if (bus.stop)                 state_d = S_IDLE;
                    else if (pc_q == bus.end_addr) state_d = S_HALT;
                    else                          state_d = S_FETCH;
                end else if (wd_tc) begin
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            ir_q          <= 16'h0000;
            imm_q         <= 16'h0000;
            instr_count_q <= 16'h0000;
            exec_first_q  <= 1'b0;
        end else begin
            exec_first_q <= (state_q != S_EXEC);
            case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (bus.start) begin
                        pc_q          <= bus.start_addr;
                        instr_count_q <= 16'h0000;
                    end
                end
                S_LATCH: begin
                    ir_q <= bus.mem_data;
                    pc_q <= pc_q + 1'b1;
                end
                S_LATCH_IMM: begin
                    imm_q <= bus.mem_data;
                    pc_q  <= pc_q + 1'b1;
                end
                S_EXEC: begin
                    if (bus.done && instr_count_q != 16'hFFFF) instr_count_q <= instr_count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr;
    assign bus.din         = din;
    assign bus.run         = run;
    assign bus.busy        = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERROR);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.error       = (state_q == S_ERROR);
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench: program-walk reference model vs. cycle trace of the sequencer.
module tb_proc_sequencer;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    proc_sequencer_if #(.AW(8)) bus ();
    proc_sequencer #(.AW(8), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] rom [256];
    always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

    int tests_run = 0;
    int tests_failed = 0;

    int lat [64];
    int stop_idx_r = -1;
    int instr_idx = 0;
    int ecnt = 0;
    bit noise = 1'b0;
    int viol = 0;
    logic [16:0] obs_q [$];
    logic [16:0] exp_q [$];
    int exp_status;
    int exp_count;
    int obs_status;
    bit hung;

    // Trace recorder and processor/stop responder.
    always @(negedge clk) begin
        if (bus.busy) obs_q.push_back({bus.run, bus.run ? bus.din : {8'h00, bus.mem_addr}});
        if (!bus.run && bus.din !== 16'h0000) viol++;
        if (bus.run) begin
            ecnt++;
            bus.done = (ecnt == lat[instr_idx]);
        end else begin
            if (ecnt > 0) begin
                if (instr_idx < 63) instr_idx++;
                ecnt = 0;
            end
            bus.done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        bus.stop = (instr_idx == stop_idx_r);
    end

    // Reference: walk the program word by word; status 0 idle, 1 halt, 2 error.
    task automatic model_run(input logic [7:0] sa, input logic [7:0] ea, input int sidx);
        logic [7:0] pc;
        logic [15:0] w, imm;
        exp_q.delete();
        exp_count = 0;
        exp_status = 1;
        pc = sa;
        if (sa == ea) return;
        for (int k = 0; k < 64; k++) begin
            w = rom[pc];
            exp_q.push_back({9'h0, pc});
            exp_q.push_back(17'h0);
            pc++;
            imm = w;
            if (w[15:13] == 3'b001) begin
                imm = rom[pc];
                exp_q.push_back({9'h0, pc});
                exp_q.push_back(17'h0);
                pc++;
            end
            exp_q.push_back({1'b1, w});
            if (lat[k] > TO) begin
                repeat (TO - 1) exp_q.push_back({1'b1, imm});
                exp_status = 2;
                return;
            end
            repeat (lat[k] - 1) exp_q.push_back({1'b1, imm});
            exp_count++;
            if (k == sidx) begin
                exp_status = 0;
                return;
            end
            if (pc == ea) return;
        end
        exp_status = 3;
    endtask

    task automatic execute(input logic [7:0] sa, input logic [7:0] ea, input int sidx);
        @(negedge clk);
        bus.start_addr = sa;
        bus.end_addr = ea;
        stop_idx_r = sidx;
        instr_idx = 0;
        ecnt = 0;
        obs_q.delete();
        viol = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 3000 && bus.busy; c++) @(negedge clk);
        hung = bus.busy;
        obs_status = bus.error ? 2 : (bus.halted ? 1 : 0);
    endtask

    function automatic int trace_diff();
        int n;
        n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) if (exp_q[i] !== obs_q[i]) return i;
        if (exp_q.size() != obs_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [16:0] obs_at(input int i);
        return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 17'h1ffff;
    endfunction

    function automatic logic [16:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 17'h1ffff;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.halted, bus.error, bus.run} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy/halted/error/run=%b want 0000", {bus.busy, bus.halted, bus.error, bus.run});
        end
        tests_run++;
        if (bus.din !== 16'h0000 || bus.mem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_bus: got din=%h mem_addr=%h want 0000/00", bus.din, bus.mem_addr);
        end
        tests_run++;
        if (bus.instr_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_count: got %h want 0000", bus.instr_count);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b halted=%b want 0/0", bus.busy, bus.halted);
        end
    endtask

    task automatic test_single_mv();
        int d;
        rom[0] = 16'h0500; rom[1] = 16'h1234; lat[0] = 2; noise = 1'b1;
        model_run(8'h00, 8'h01, -1);
        execute(8'h00, 8'h01, -1);
        d = trace_diff();
        tests_run++;
        if (d >= 0) begin
            tests_failed++;
            $display("FAIL single_mv_trace @%0d: got %h want %h", d, obs_at(d), exp_at(d));
        end
        tests_run++;
        if (hung || obs_status != 1) begin
            tests_failed++;
            $display("FAIL single_mv_status: got %0d (hung=%0d) want 1", obs_status, hung);
        end
        tests_run++;
        if (bus.instr_count !== 16'd1 || viol != 0) begin
            tests_failed++;
            $display("FAIL single_mv_count: got count=%0d din_viol=%0d want 1/0", bus.instr_count, viol);
        end
    endtask

    task automatic test_mvi();
        int d;
        rom[0] = 16'h2C00; rom[1] = 16'hBEEF; lat[0] = 3; noise = 1'b1;
        model_run(8'h00, 8'h02, -1);
        execute(8'h00, 8'h02, -1);
        d = trace_diff();
        tests_run++;
        if (d >= 0) begin
            tests_failed++;
            $display("FAIL mvi_trace @%0d: got %h want %h", d, obs_at(d), exp_at(d));
        end
        tests_run++;
        if (obs_at(4) !== {1'b1, 16'h2C00} || obs_at(5) !== {1'b1, 16'hBEEF}) begin
            tests_failed++;
            $display("FAIL mvi_din: got %h,%h want 12c00,1beef", obs_at(4), obs_at(5));
        end
        tests_run++;
        if (hung || obs_status != 1 || bus.instr_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL mvi_status: got %0d count=%0d want 1/1", obs_status, bus.instr_count);
        end
    endtask

    task automatic test_timeout();
        int d, runs;
        rom[5] = 16'h4000; lat[0] = 99; noise = 1'b0;
        model_run(8'h05, 8'h06, -1);
        execute(8'h05, 8'h06, -1);
        d = trace_diff();
        runs = 0;
        foreach (obs_q[i]) if (obs_q[i][16]) runs++;
        tests_run++;
        if (d >= 0) begin
            tests_failed++;
            $display("FAIL timeout_trace @%0d: got %h want %h", d, obs_at(d), exp_at(d));
        end
        tests_run++;
        if (runs != TO) begin
            tests_failed++;
            $display("FAIL timeout_run_cycles: got %0d want %0d", runs, TO);
        end
        tests_run++;
        if (hung || obs_status != 2 || bus.error !== 1'b1 || bus.run !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_error: got status=%0d error=%b run=%b want 2/1/0", obs_status, bus.error, bus.run);
        end
        lat[0] = 1;
        model_run(8'h05, 8'h06, -1);
        execute(8'h05, 8'h06, -1);
        tests_run++;
        if (hung || obs_status != 1 || bus.instr_count !== 16'd1 || trace_diff() >= 0) begin
            tests_failed++;
            $display("FAIL timeout_restart: got status=%0d count=%0d want 1/1", obs_status, bus.instr_count);
        end
    endtask

    task automatic test_tc_boundary();
        rom[30] = 16'h8000; lat[0] = TO; noise = 1'b1;
        model_run(8'd30, 8'd31, -1);
        execute(8'd30, 8'd31, -1);
        tests_run++;
        if (hung || obs_status != 1 || bus.instr_count !== 16'd1 || trace_diff() >= 0) begin
            tests_failed++;
            $display("FAIL tc_boundary: got status=%0d count=%0d want 1/1", obs_status, bus.instr_count);
        end
    endtask

    task automatic test_stop();
        int d;
        rom[20] = 16'h4080; rom[21] = 16'h6100; rom[22] = 16'h8180; rom[23] = 16'hA200;
        lat[0] = 3; lat[1] = 4; lat[2] = 2; lat[3] = 5; noise = 1'b1;
        model_run(8'd20, 8'd24, 1);
        execute(8'd20, 8'd24, 1);
        d = trace_diff();
        tests_run++;
        if (d >= 0) begin
            tests_failed++;
            $display("FAIL stop_trace @%0d: got %h want %h", d, obs_at(d), exp_at(d));
        end
        tests_run++;
        if (hung || obs_status != 0 || bus.instr_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL stop_idle: got status=%0d count=%0d want 0/2", obs_status, bus.instr_count);
        end
    endtask

    task automatic test_imm_at_end();
        rom[10] = 16'h2400; rom[11] = 16'h1234; rom[12] = 16'h0500;
        lat[0] = 2; lat[1] = 1; noise = 1'b0;
        model_run(8'd10, 8'd11, 1);
        execute(8'd10, 8'd11, 1);
        tests_run++;
        if (hung || obs_status != 0 || bus.instr_count !== 16'd2 || trace_diff() >= 0) begin
            tests_failed++;
            $display("FAIL imm_at_end: got status=%0d count=%0d want 0/2", obs_status, bus.instr_count);
        end
    endtask

    task automatic test_wrap();
        int d;
        rom[8'hFE] = 16'h0500; rom[8'hFF] = 16'h6000; rom[8'h00] = 16'hE000;
        lat[0] = 1; lat[1] = 2; lat[2] = 1; noise = 1'b1;
        model_run(8'hFE, 8'h01, -1);
        execute(8'hFE, 8'h01, -1);
        d = trace_diff();
        tests_run++;
        if (d >= 0) begin
            tests_failed++;
            $display("FAIL wrap_trace @%0d: got %h want %h", d, obs_at(d), exp_at(d));
        end
        tests_run++;
        if (hung || obs_status != 1 || bus.instr_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL wrap_halt: got status=%0d count=%0d want 1/3", obs_status, bus.instr_count);
        end
    endtask

    task automatic test_direct_halt();
        execute(8'h50, 8'h50, -1);
        tests_run++;
        if (hung || obs_status != 1 || obs_q.size() != 0 || bus.instr_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL direct_halt: got status=%0d busy_cycles=%0d count=%0d want 1/0/0", obs_status, obs_q.size(), bus.instr_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] sa, pc;
        int k, sidx, d, r;
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < 256; a++) begin
                rom[a] = 16'($urandom);
                if ($urandom_range(0, 2) == 0) rom[a][15:13] = 3'b001;
            end
            for (int j = 0; j < 64; j++) begin
                r = $urandom_range(0, 19);
                lat[j] = (r < 14) ? $urandom_range(1, 5) : (r < 17) ? TO : (r < 18) ? TO - 1 : TO + 5;
            end
            sa = 8'($urandom);
            k = $urandom_range(0, 6);
            pc = sa;
            for (int j = 0; j < k; j++) pc = pc + ((rom[pc][15:13] == 3'b001) ? 8'd2 : 8'd1);
            sidx = (k > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, k - 1) : -1;
            noise = 1'($urandom_range(0, 1));
            model_run(sa, pc, sidx);
            execute(sa, pc, sidx);
            d = trace_diff();
            tests_run++;
            if (d >= 0) begin
                tests_failed++;
                $display("FAIL rand%0d_trace @%0d: got %h want %h", it, d, obs_at(d), exp_at(d));
            end
            tests_run++;
            if (hung || obs_status != exp_status) begin
                tests_failed++;
                $display("FAIL rand%0d_status: got %0d (hung=%0d) want %0d", it, obs_status, hung, exp_status);
            end
            tests_run++;
            if (bus.instr_count !== 16'(exp_count)) begin
                tests_failed++;
                $display("FAIL rand%0d_count: got %0d want %0d", it, bus.instr_count, exp_count);
            end
            tests_run++;
            if (viol != 0) begin
                tests_failed++;
                $display("FAIL rand%0d_din_idle: got %0d nonzero din cycles want 0", it, viol);
            end
        end
    endtask

    task automatic test_async_reset();
        int c;
        rom[40] = 16'h4000; rom[41] = 16'h6080; lat[0] = 1; lat[1] = 99; noise = 1'b0;
        @(negedge clk);
        bus.start_addr = 8'd40; bus.end_addr = 8'd42; stop_idx_r = -1; instr_idx = 0; ecnt = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (!(bus.run && instr_idx == 1) && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (c >= 200 || bus.run !== 1'b1 || bus.instr_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL areset_setup: got run=%b count=%0d waited=%0d want 1/1", bus.run, bus.instr_count, c);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.run !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_run: got %b want 0", bus.run);
        end
        tests_run++;
        if ({bus.busy, bus.halted, bus.error} !== 3'b000) begin
            tests_failed++;
            $display("FAIL areset_flags: got %b want 000", {bus.busy, bus.halted, bus.error});
        end
        tests_run++;
        if (bus.din !== 16'h0000 || bus.mem_addr !== 8'h00 || bus.instr_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL areset_bus: got din=%h addr=%h count=%h want 0", bus.din, bus.mem_addr, bus.instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.run !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_no_resume: got busy=%b run=%b want 0/0", bus.busy, bus.run);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        for (int j = 0; j < 64; j++) lat[j] = 1;
        bus.start = 1'b0;
        bus.start_addr = 8'h00;
        bus.end_addr = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_mv();
        test_mvi();
        test_timeout();
        test_tc_boundary();
        test_stop();
        test_imm_at_end();
        test_wrap();
        test_direct_halt();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
